uart_rx_byte_strobe: RTL and testbench
======================================

// Module: uart_rx_byte_strobe
// PURPOSE
//  UART receiver (8N1, LSB first) directly upstream of the command accumulator.
//  Oversamples the rx pin and recovers bytes, presenting each on data_out with
//  data_valid held high for STROBE_CYCLES (drives accumulator input_data/accumulate).
//  Flags framing errors and overruns; one instance each for the BLE and host UARTs.
// PARAMETERS
//  CLKS_PER_BIT   434  clk cycles per UART bit (50 MHz / 115200); must be >= 4
//  STROBE_CYCLES  4    data_valid high time in clk cycles; must be >= 1 and < 9*CLKS_PER_BIT
// PORTS
//  clk          in   1  system clock
//  reset        in   1  asynchronous, active-high reset
//  rx           in   1  asynchronous UART line, idle high
//  rx_enable    in   1  0 = receiver held in IDLE, in-flight byte discarded
//  data_out     out  8  last good byte; stable while data_valid is high
//  data_valid   out  1  high for exactly STROBE_CYCLES per good byte
//  frame_error  out  1  1-cycle pulse: stop bit sampled low
//  overrun      out  1  1-cycle pulse: good byte completed while data_valid high
//  busy         out  1  high while FSM is outside IDLE
// BEHAVIOUR
//  Reset: data_out=0x00, data_valid=0, frame_error=0, overrun=0, busy=0,
//   synchronizer flops=1, FSM=IDLE, all counters=0. Reset mid-byte aborts it.
//  rx passes a 2-flop synchronizer (rx_s); all sampling uses rx_s only.
//  FSM states / transitions:
//   IDLE : rx_enable && rx_s==0 -> START, bit counter cleared.
//   START: wait CLKS_PER_BIT/2 (integer divide) cycles, sample rx_s;
//          0 -> DATA; 1 -> IDLE (glitch rejected, no flag).
//   DATA : sample every CLKS_PER_BIT cycles into shift reg bit[idx], idx 0..7;
//          after bit 7 -> STOP.
//   STOP : after CLKS_PER_BIT cycles sample rx_s;
//          1 -> good byte, -> IDLE; 0 -> frame_error pulse, -> BREAK.
//   BREAK: wait for rx_s==1, then -> IDLE (long low line never re-triggers).
//   rx_enable==0 in any state -> IDLE next cycle; strobe in progress completes.
//  Good byte, strobe idle: data_out loaded and data_valid rises on the cycle
//   after the stop sample; stays high STROBE_CYCLES cycles, then low >= 1 cycle.
//  Good byte while data_valid high: byte dropped, data_out unchanged,
//   overrun pulses 1 cycle, strobe counter not restarted.
//  Frame error: data_out and data_valid untouched.
//  Strobe counter: width $clog2(STROBE_CYCLES+1); bit-timing counter width
//   $clog2(CLKS_PER_BIT); both saturate-free, reloaded at each phase.
//  Guaranteed: data_valid never high on two consecutive bytes without a low
//   cycle between them (accumulator needs the falling edge).
//  All outputs are registered; no combinational path rx -> outputs.
// STRUCTURE
//  Shared package uart_pkg: FSM state enum (IDLE, START, DATA, STOP, BREAK),
//   default CLKS_PER_BIT, and protocol constants CR=0x0D, SOF=0xBE, EOF=0xEF.
//  One sub-module: sync_2ff (generic 2-flop bit synchronizer, reset value param).
//  Strobe generator is a separate always block in this module, independent of
//   the FSM so reception of the next byte overlaps the strobe.
// TESTING (bench uses CLKS_PER_BIT=8, STROBE_CYCLES=3)
//  1. Send 0xA5 at 8 clk/bit -> data_out=0xA5, data_valid high exactly 3 cycles,
//     rising 1 cycle after stop sample; frame_error=overrun=0.
//  2. rx low 2 cycles then high -> busy pulses, returns to IDLE, no data_valid.
//  3. Send 0x3C with stop bit 0, rx held low 40 cycles -> one frame_error pulse,
//     data_valid stays 0, busy high until rx returns high, then 0x55 received OK.
//  4. STROBE_CYCLES=100: 0x11 then 0x22 back-to-back -> data_out stays 0x11,
//     one overrun pulse at 0x22 stop sample.
//  5. Back-to-back 0xBE, 0xEF -> two strobes, data_valid low between them,
//     data_out 0xBE then 0xEF.
//  6. reset asserted mid-DATA of 0x7E -> all outputs 0 at once; after release
//     0x81 received correctly; rx_enable=0 during a byte -> byte discarded.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, default bit timing and the
// framing bytes the downstream command accumulator recognises.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } uart_state_t;

    // 50 MHz system clock, 115200 baud
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    localparam logic [7:0] CR  = 8'h0D;
    localparam logic [7:0] SOF = 8'hBE;
    localparam logic [7:0] EOF = 8'hEF;

endpackage : uart_pkg

// File: rtl/uart_rx_byte_strobe_sync_2ff.sv
// Generic two-flop synchronizer for a single asynchronous bit, with a
// configurable reset value so idle-high lines come out of reset idle.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule : sync_2ff

// File: rtl/uart_rx_byte_strobe.sv
// 8N1 UART receiver that presents each good byte with a fixed-length
// data_valid strobe, and flags framing errors and strobe overruns.
module uart_rx_byte_strobe
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT  = DEFAULT_CLKS_PER_BIT,
    parameter int STROBE_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rx_enable,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       frame_error,
    output logic       overrun,
    output logic       busy
);

    localparam int CNT_W  = $clog2(CLKS_PER_BIT);
    localparam int STRB_W = $clog2(STROBE_CYCLES + 1);

    localparam logic [CNT_W-1:0]  HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [STRB_W-1:0] STRB_LOAD = STRB_W'(STROBE_CYCLES);
    localparam logic [STRB_W-1:0] STRB_ONE  = STRB_W'(1);

    logic w_rx_s;

    uart_state_t       r_state;
    uart_state_t       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [2:0]        r_idx;
    logic [2:0]        w_idx_nxt;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_nxt;
    logic              w_good;
    logic              w_ferr;

    logic [7:0]        r_data_out;
    logic              r_data_valid;
    logic [STRB_W-1:0] r_strb_cnt;
    logic              r_frame_err;
    logic              r_overrun;
    logic              r_busy;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rx (
        .clk   (clk),
        .reset (reset),
        .i_d   (rx),
        .o_q   (w_rx_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_idx   <= w_idx_nxt;
            r_shift <= w_shift_nxt;
        end
    end

    // Samples are taken on the last cycle of each timed phase; the counter
    // restarts from zero whenever a phase begins.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt + 1'b1;
        w_idx_nxt   = r_idx;
        w_shift_nxt = r_shift;
        w_good      = 1'b0;
        w_ferr      = 1'b0;

        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (rx_enable && !w_rx_s) begin
                    w_state_nxt = START;
                    w_idx_nxt   = '0;
                end
            end
            START: begin
                if (r_cnt == HALF_LAST) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt          = '0;
                    w_shift_nxt[r_idx] = w_rx_s;
                    w_idx_nxt          = r_idx + 1'b1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                if (r_cnt == BIT_LAST) begin
                    w_cnt_nxt = '0;
                    if (w_rx_s) begin
                        w_good      = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_ferr      = 1'b1;
                        w_state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                w_cnt_nxt = '0;
                if (w_rx_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_cnt_nxt   = '0;
                w_state_nxt = IDLE;
            end
        endcase

        // Disabling discards whatever is in flight, including a stop sample
        if (!rx_enable) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
            w_good      = 1'b0;
            w_ferr      = 1'b0;
        end
    end

    // Strobe generator runs independently of the FSM so the next byte can be
    // received while the current one is still being presented.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_data_out   <= '0;
            r_data_valid <= 1'b0;
            r_strb_cnt   <= '0;
            r_overrun    <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (r_data_valid) begin
                if (r_strb_cnt == STRB_ONE) begin
                    r_data_valid <= 1'b0;
                    r_strb_cnt   <= '0;
                end else begin
                    r_strb_cnt <= r_strb_cnt - 1'b1;
                end
                if (w_good) begin
                    r_overrun <= 1'b1;
                end
            end else if (w_good) begin
                r_data_out   <= r_shift;
                r_data_valid <= 1'b1;
                r_strb_cnt   <= STRB_LOAD;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_frame_err <= w_ferr;
            r_busy      <= (w_state_nxt != IDLE);
        end
    end

    assign data_out    = r_data_out;
    assign data_valid  = r_data_valid;
    assign frame_error = r_frame_err;
    assign overrun     = r_overrun;
    assign busy        = r_busy;

endmodule : uart_rx_byte_strobe

// File: tb/tb_uart_rx_byte_strobe.sv
// Directed bench for uart_rx_byte_strobe: a per-cycle expected-output timeline
// built from bit-timing arithmetic, plus literal checks on recorded history.
module tb_uart_rx_byte_strobe;
    import uart_pkg::*;

    localparam int CPB  = 8;
    localparam int STRB = 3;
    localparam int MAXC = 4096;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx = 1'b1;
    logic       rx2 = 1'b1;
    logic       rx_en = 1'b1;

    logic [7:0] d1, d2;
    logic       v1, f1, o1, b1;
    logic       v2, f2, o2, b2;

    uart_rx_byte_strobe #(.CLKS_PER_BIT(CPB), .STROBE_CYCLES(STRB)) u_dut (
        .clk(clk), .reset(reset), .rx(rx), .rx_enable(rx_en),
        .data_out(d1), .data_valid(v1), .frame_error(f1), .overrun(o1), .busy(b1)
    );

    uart_rx_byte_strobe #(.CLKS_PER_BIT(CPB), .STROBE_CYCLES(100)) u_dut_long (
        .clk(clk), .reset(reset), .rx(rx2), .rx_enable(1'b1),
        .data_out(d2), .data_valid(v2), .frame_error(f2), .overrun(o2), .busy(b2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // Expected value of each output just after posedge number c
    bit [7:0] e_data [MAXC];
    bit       e_valid[MAXC];
    bit       e_ferr [MAXC];
    bit       e_ovr  [MAXC];
    bit       e_busy [MAXC];

    bit [7:0] h_data [MAXC];
    bit       h_valid[MAXC];
    bit       h_ferr [MAXC];
    bit       h_busy [MAXC];
    bit [7:0] h_data2[MAXC];
    bit       h_valid2[MAXC];
    bit       h_ovr2 [MAXC];

    int checks = 0;
    int failures = 0;

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            h_data[cyc]   = d1;
            h_valid[cyc]  = v1;
            h_ferr[cyc]   = f1;
            h_busy[cyc]   = b1;
            h_data2[cyc]  = d2;
            h_valid2[cyc] = v2;
            h_ovr2[cyc]   = o2;
            checks++;
            if ({d1, v1, f1, o1, b1} !== {e_data[cyc], e_valid[cyc], e_ferr[cyc], e_ovr[cyc], e_busy[cyc]}) begin
                failures++;
                $display("FAIL timeline cyc=%0d got data=%h vld=%b fe=%b ovr=%b busy=%b want data=%h vld=%b fe=%b ovr=%b busy=%b",
                         cyc, d1, v1, f1, o1, b1,
                         e_data[cyc], e_valid[cyc], e_ferr[cyc], e_ovr[cyc], e_busy[cyc]);
            end
        end
    end

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h", name, got, want);
        end
    endtask

    function automatic void busy_range(input int a, input int b, input bit v);
        for (int i = a; i <= b && i < MAXC; i++) e_busy[i] = v;
    endfunction

    function automatic void data_from(input int a, input bit [7:0] v);
        for (int i = a; i < MAXC; i++) e_data[i] = v;
    endfunction

    // A byte whose stop bit is sampled good at posedge s
    function automatic void model_good(input int s, input bit [7:0] v);
        if (e_valid[s-1]) begin
            e_ovr[s] = 1'b1;
        end else begin
            for (int i = 0; i < STRB; i++) e_valid[s+i] = 1'b1;
            data_from(s, v);
        end
    endfunction

    function automatic int cnt_hist(input int sel, input int a, input int b);
        int n = 0;
        for (int i = a; i < b && i < MAXC; i++) begin
            case (sel)
                0: n += int'(h_valid[i]);
                1: n += int'(h_ferr[i]);
                2: n += int'(h_busy[i]);
                3: n += int'(h_valid2[i]);
                default: n += int'(h_ovr2[i]);
            endcase
        end
        return n;
    endfunction

    task automatic setrx(input int line, input logic v);
        if (line == 1) rx = v;
        else rx2 = v;
    endtask

    // Start bit first sampled by the synchronizer at posedge k; each bit is
    // CPB cycles, so start is detected at k+2, the stop bit sampled at k+78.
    // abort_kind: 0 none, 1 drop rx_enable, 2 assert reset (before data bit abort_bit)
    task automatic send(input int line, input bit [7:0] b, input bit stop, input int hold,
                        input int abort_bit, input int abort_kind, input int gap, output int k);
        k = cyc + 1;
        if (line == 1) begin
            if (stop) begin
                busy_range(k + 2, k + 77, 1'b1);
                if (abort_kind == 0) model_good(k + 78, b);
            end else begin
                busy_range(k + 2, k + 73 + hold, 1'b1);
                e_ferr[k + 78] = 1'b1;
            end
        end
        setrx(line, 1'b0);
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            if (abort_kind != 0 && i == abort_bit) begin
                if (abort_kind == 1) begin
                    rx_en = 1'b0;
                    busy_range(cyc + 1, k + 77, 1'b0);
                    setrx(line, 1'b1);
                    repeat (80) @(negedge clk);
                    rx_en = 1'b1;
                end else begin
                    #2;
                    reset = 1'b1;
                    setrx(line, 1'b1);
                    busy_range(cyc + 1, k + 77, 1'b0);
                    data_from(cyc + 1, 8'h00);
                    #1;
                    chk("reset_mid_byte", int'({d1, v1, f1, o1, b1}), 0);
                    repeat (3) @(negedge clk);
                    #2;
                    reset = 1'b0;
                end
                repeat (gap) @(negedge clk);
                return;
            end
            setrx(line, b[i]);
            repeat (CPB) @(negedge clk);
        end
        setrx(line, stop);
        if (stop) begin
            repeat (CPB) @(negedge clk);
        end else begin
            repeat (hold) @(negedge clk);
            setrx(line, 1'b1);
        end
        repeat (gap) @(negedge clk);
    endtask

    initial begin
        int k_a5, k_g, k_3c, k_55, k_be, k_ef, k_11, k_22, k_7e, k_81, k_ab, k_cr;

        #7;
        chk("reset_state", int'({d1, v1, f1, o1, b1}), 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        repeat (5) @(negedge clk);

        send(1, 8'hA5, 1'b1, 0, 0, 0, 10, k_a5);

        k_g = cyc + 1;
        busy_range(k_g + 2, k_g + 5, 1'b1);
        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (12) @(negedge clk);

        send(1, 8'h3C, 1'b0, 40, 0, 0, 10, k_3c);
        send(1, 8'h55, 1'b1, 0, 0, 0, 10, k_55);

        send(1, SOF, 1'b1, 0, 0, 0, 0, k_be);
        send(1, EOF, 1'b1, 0, 0, 0, 10, k_ef);

        send(2, 8'h11, 1'b1, 0, 0, 0, 0, k_11);
        send(2, 8'h22, 1'b1, 0, 0, 0, 120, k_22);

        send(1, 8'h7E, 1'b1, 0, 3, 2, 20, k_7e);
        send(1, 8'h81, 1'b1, 0, 0, 0, 10, k_81);
        send(1, 8'h5A, 1'b1, 0, 4, 1, 10, k_ab);
        send(1, CR, 1'b1, 0, 0, 0, 10, k_cr);

        chk("a5_before_rise", int'(h_valid[k_a5 + 77]), 0);
        chk("a5_rise", int'(h_valid[k_a5 + 78]), 1);
        chk("a5_width", cnt_hist(0, k_a5 + 70, k_a5 + 90), 3);
        chk("a5_data", int'(h_data[k_a5 + 78]), 8'hA5);
        chk("a5_no_ferr", cnt_hist(1, k_a5, k_a5 + 90), 0);

        chk("glitch_busy_on", int'(h_busy[k_g + 2]), 1);
        chk("glitch_busy_off", int'(h_busy[k_g + 6]), 0);
        chk("glitch_no_valid", cnt_hist(0, k_g, k_g + 14), 0);

        chk("ferr_count", cnt_hist(1, k_3c, k_55), 1);
        chk("ferr_pos", int'(h_ferr[k_3c + 78]), 1);
        chk("ferr_no_valid", cnt_hist(0, k_3c, k_55), 0);
        chk("break_busy", int'(h_busy[k_3c + 110]), 1);
        chk("after_break_data", int'(h_data[k_55 + 78]), 8'h55);

        chk("sof_data", int'(h_data[k_be + 78]), 8'hBE);
        chk("gap_low", int'(h_valid[k_be + 81]), 0);
        chk("eof_data", int'(h_data[k_ef + 78]), 8'hEF);

        chk("long_first", int'(h_data2[k_11 + 78]), 8'h11);
        chk("long_ovr_pos", int'(h_ovr2[k_22 + 78]), 1);
        chk("long_ovr_count", cnt_hist(4, k_11, k_22 + 200), 1);
        chk("long_data_kept", int'(h_data2[k_22 + 80]), 8'h11);
        chk("long_width", cnt_hist(3, k_11, k_22 + 200), 100);

        chk("after_reset_data", int'(h_data[k_81 + 78]), 8'h81);
        chk("disabled_no_valid", cnt_hist(0, k_ab, k_cr), 0);
        chk("disabled_busy_off", cnt_hist(2, k_ab + 40, k_cr), 0);
        chk("cr_data", int'(h_data[k_cr + 78]), CR);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_uart_rx_byte_strobe
